// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg
//   Shared definitions for the 1001/1110 serial pattern generator:
//   FSM state encoding, the fixed 4-bit codes, the pattern-select codes
//   and a helper that turns a select code into a left-aligned load word.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] PAT_1001 = 4'b1001;
  localparam logic [3:0] PAT_1110 = 4'b1110;

  localparam logic [1:0] SEL_1001   = 2'b00;
  localparam logic [1:0] SEL_1110   = 2'b01;
  localparam logic [1:0] SEL_BOTH   = 2'b10;
  localparam logic [1:0] SEL_CUSTOM = 2'b11;

  // Load image for the shifter: word is left-aligned, MSB goes out first.
  typedef struct packed {
    logic [7:0] word;
    logic       len8;
  } pat_t;

  function automatic pat_t pattern_for(input logic [1:0] sel, input logic [7:0] pat_in);
    pat_t p;
    p.word = 8'h00;
    p.len8 = 1'b0;
    case (sel)
      SEL_1001: begin
        p.word = {PAT_1001, 4'b0000};
        p.len8 = 1'b0;
      end
      SEL_1110: begin
        p.word = {PAT_1110, 4'b0000};
        p.len8 = 1'b0;
      end
      SEL_BOTH: begin
        p.word = {PAT_1001, PAT_1110};
        p.len8 = 1'b1;
      end
      SEL_CUSTOM: begin
        p.word = pat_in;
        p.len8 = 1'b1;
      end
      default: begin
        p.word = 8'h00;
        p.len8 = 1'b0;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// seq_gen_shifter
//   8-bit load/shift register plus a 3-bit down-counting bit counter.
//   The MSB of the register is the serial output bit, so the register
//   itself is the registered `out` of the generator.
//
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     clr_i        clear register and counter (highest priority)
//     load_i       load pat_i.word; counter = length-1
//     shift_i      shift left by one, counter decrements (saturates at 0)
//     pat_i        left-aligned word and length select (4 or 8 bits)
//     bit_o        current serial bit (register MSB)
//     last_bit_o   the bit on bit_o is the last one of the frame
module seq_gen_shifter
  import seq_gen_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic shift_i,
  input  pat_t pat_i,
  output logic bit_o,
  output logic last_bit_o
);

  logic [7:0] data_q;
  logic [2:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      data_q <= pat_i.word;
      cnt_q  <= pat_i.len8 ? 3'd7 : 3'd3;
    end else if (shift_i) begin
      data_q <= {data_q[6:0], 1'b0};
      if (cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  assign bit_o      = data_q[7];
  assign last_bit_o = (cnt_q == 3'd0);

endmodule

// File: rtl/seq_gen_1001_1110.sv
// seq_gen_1001_1110
//   Serial pattern generator: sends reps+1 frames of the selected code
//   (1001, 1110, 10011110 or a custom byte) MSB-first, one bit per clock,
//   with GAP_BITS idle cycles between frames of one command.
//
//   Ports:
//     clk, rst_n    clock, async active-low reset
//     start         command strobe, taken only while ready=1
//     sel, pat_in   pattern select / custom word (latched at accept)
//     reps          frame count minus one (latched at accept)
//     abort         cancel the running command, no done pulse
//     ready         high in IDLE
//     out           serial bit (shifter MSB, registered)
//     out_valid     out carries a pattern bit
//     frame_start   first bit of each frame
//     done          one-cycle pulse after the last bit of the last frame
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   ST_IDLE  | waiting for start, ready=1
//   ST_SHIFT | a frame bit is on out this cycle
//   ST_GAP   | inter-frame idle, out=0, out_valid=0
//   ST_DONE  | done pulse cycle, back to IDLE next
module seq_gen_1001_1110
  import seq_gen_pkg::*;
#(
  parameter int GAP_BITS = 2,
  parameter int REP_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic [7:0]       pat_in,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             done
);

  // A zero-width counter is not legal, so GAP_BITS=0 still gets one bit.
  localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_e           state_q;
  pat_t             pat_q;
  logic [REP_W-1:0] frame_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic             out_valid_q;
  logic             frame_start_q;
  logic             done_q;
  logic             ready_q;

  logic accept;
  logic frame_end;
  logic last_frame;
  logic gap_end;
  logic reload;
  logic sh_load;
  logic sh_shift;
  logic sh_clr;
  pat_t sh_pat;
  logic sh_bit;
  logic sh_last;

  always_comb begin
    accept     = 1'b0;
    frame_end  = 1'b0;
    last_frame = 1'b0;
    gap_end    = 1'b0;
    reload     = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_clr     = 1'b0;
    sh_pat     = pat_q;

    accept     = (state_q == ST_IDLE) && start;
    frame_end  = (state_q == ST_SHIFT) && sh_last;
    last_frame = (frame_cnt_q == '0);
    gap_end    = (state_q == ST_GAP) && (gap_cnt_q == '0);
    // Next frame starts straight from SHIFT only when there is no gap.
    reload     = !abort && ((frame_end && !last_frame && (GAP_BITS == 0)) || gap_end);

    sh_load    = accept || reload;
    // Clearing at a frame end that is not followed by a reload forces out=0
    // through GAP and DONE without any extra output muxing.
    sh_clr     = (abort && (state_q != ST_IDLE)) || (frame_end && !reload);
    sh_shift   = (state_q == ST_SHIFT) && !sh_last && !abort;
    sh_pat     = accept ? pattern_for(sel, pat_in) : pat_q;
  end

  seq_gen_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (sh_clr),
    .load_i     (sh_load),
    .shift_i    (sh_shift),
    .pat_i      (sh_pat),
    .bit_o      (sh_bit),
    .last_bit_o (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pat_q         <= '0;
      frame_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            pat_q         <= sh_pat;
            frame_cnt_q   <= reps;
            gap_cnt_q     <= '0;
            state_q       <= ST_SHIFT;
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (abort) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
            ready_q     <= 1'b1;
          end else if (!sh_last) begin
            out_valid_q <= 1'b1;
          end else if (last_frame) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            frame_cnt_q <= frame_cnt_q - REP_W'(1);
            if (reload) begin
              out_valid_q   <= 1'b1;
              frame_start_q <= 1'b1;
            end else begin
              gap_cnt_q <= GAP_LOAD;
              state_q   <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (abort) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
            ready_q     <= 1'b1;
          end else if (gap_end) begin
            state_q       <= ST_SHIFT;
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end

        ST_DONE: begin
          state_q     <= ST_IDLE;
          frame_cnt_q <= '0;
          gap_cnt_q   <= '0;
          ready_q     <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out         = sh_bit;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;
  assign ready       = ready_q;

endmodule

// File: doc/seq_gen_1001_1110.md
# seq_gen_1001_1110

Serial pattern generator that drives a single-bit stream carrying the 4-bit codes 1001 and 1110, or an 8-bit custom word, MSB-first at one bit per clock. It is the stimulus and transmit side of the 1001/1110 sequence detectors. Its `out` port connects directly to a detector's serial `in`. A host issues one command (pattern, repetition count) through a start/ready handshake, then waits for a `done` pulse.

## Interface
- `GAP_BITS`, default 2: number of idle cycles between consecutive frames of one command. 0 means frames are sent back-to-back.
- `REP_W`, default 4: width of the repetition field.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; accepted only in a cycle where `ready`=1.
- `sel`  in  2  pattern select:
  - 00 = 1001 (4 bits)
  - 01 = 1110 (4 bits)
  - 10 = 10011110 (8 bits)
  - 11 = `pat_in` (8 bits)
- `pat_in`  in  8  custom word, used only when `sel`=11.
- `reps`  in  REP_W  frame count minus one; the command sends `reps`+1 frames.
- `abort`  in  1  synchronous cancel of the command in progress.
- `ready`  out  1  high in IDLE only.
- `out`  out  1  serial data bit; registered.
- `out_valid`  out  1  high when `out` carries a pattern bit; registered.
- `frame_start`  out  1  high with the first bit of each frame; registered.
- `done`  out  1  one-cycle pulse after the final bit of the final frame; registered.

## Operation
- States:
  - IDLE: `ready`=1; on `start`, go to SHIFT.
  - SHIFT: emit one bit per cycle; after the last bit of a frame, go to GAP, or to SHIFT (if `GAP_BITS`=0 and frames remain), or to DONE (last frame).
  - GAP: hold for `GAP_BITS` cycles, then reload the pattern and go to SHIFT.
  - DONE: one cycle, then IDLE.
- Command capture: `sel`, `pat_in` and `reps` are latched on the accept cycle. Changes to them while busy are ignored.
- Pattern load: the shifter takes an 8-bit left-aligned word plus a length of 4 or 8. The MSB is shifted out first.
- Counters:
  - bit counter: 3 bits, counts down length−1 to 0.
  - frame counter: REP_W bits, loaded with `reps`, decremented at each frame end. Last frame when it equals 0.
  - gap counter: $clog2(`GAP_BITS`+1) bits.
  - No counter may wrap. `reps` = all-ones sends 2^REP_W frames exactly.
- `start` while `ready`=0 is dropped; there is no queue.
- GAP cycles: `out`=0, `out_valid`=0. No gap is inserted after the last frame.
- `abort`:
  - In SHIFT, GAP or DONE, the next state is IDLE.
  - `out_valid`, `frame_start` and `done` are 0 from the next cycle.
  - `done` is not pulsed for an aborted command.
  - `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, the start is accepted.
- Reset, including mid-frame:
  - state = IDLE, all counters cleared.
  - `out`=0, `out_valid`=0, `frame_start`=0, `done`=0, `ready`=1.

## Timing
- Latency: the first bit is on `out` in the cycle after the accept edge, with `out_valid`=1 and `frame_start`=1.
- Frame length: 4 cycles for `sel` 00/01, 8 cycles for 10/11.
- Total command duration from first bit to `done` = F·L + (F−1)·`GAP_BITS` cycles, then 1 cycle of `done`. Here F = frame count (`reps`+1) and L = frame length.
- `done` is high in the cycle after the last bit. `ready` returns to 1 one cycle later, and a new `start` may be accepted in that same cycle.
- Minimum spacing between consecutive commands: 1 idle cycle.

## Structure
- Shared package `seq_gen_pkg`:
  - state encoding (IDLE, SHIFT, GAP, DONE)
  - constants PAT_1001 = 4'b1001, PAT_1110 = 4'b1110
  - `sel` code constants
- Sub-module `seq_gen_shifter`: 8-bit load/shift register with a length input and a `last_bit` flag. The top level holds the FSM, the frame and gap counters, and the output registers.

## Test plan
- Reset released, `GAP_BITS`=2, `sel`=00, `reps`=1, `start` at cycle 0. Required response:
  - `out_valid` over cycles 1–10 is 1111001111; `out` in cycles 1–4 and 7–10 is 1001 each time.
  - `frame_start` high at cycles 1 and 7.
  - `done` high at cycle 11, `ready` high at cycle 12.
- `sel`=10, `reps`=0 → `out` = 1,0,0,1,1,1,1,0 in cycles 1–8; `done` at cycle 9. When the output is fed into the Mealy detector, the detector reports 1001 and then 1110.
- `sel`=11, `pat_in`=8'hA5, `reps`=2, `GAP_BITS`=0 → 24 contiguous valid bits, 10100101 repeated ×3. `start` pulses during the command are ignored.
- `abort` at the 3rd bit of frame 2 → `out_valid`=0 from the next cycle, no `done`, `ready`=1 one cycle after the abort.
- `rst_n` low mid-frame → all outputs 0 and `ready`=1 immediately (asynchronous). After release, a fresh `start` produces the first bit one cycle after accept.
- `reps` = 4'hF, `sel`=01 → exactly 16 frames of 1110, with the frame counter never wrapping.
